dir_dram_bridge: RTL

//  Parametrised DRAM bridge between the control FSM and an AXI-lite-style DRAM slave; successor to the fixed
//  4-index/64-bit Data_Dir access path. It packs and unpacks directory records of NUM_IDX indices plus a date.
//  It adds a masked read-modify-write (RMW) op and error reporting. One outstanding request at a time.

---
 rtl/dir_dram_bridge.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/dir_dram_bridge.sv
// Directory-record bridge to an AXI-lite-style DRAM slave: read, write and masked read-modify-write
// of NUM_IDX index fields plus a date, one transaction in flight at a time.
module dir_dram_bridge #(
    parameter int          NUM_IDX   = 4,
    parameter int          IDX_W     = 12,
    parameter int          NO_W      = 8,
    parameter int          ADDR_W    = 17,
    parameter int          DATA_W    = 64,
    parameter int unsigned BASE_ADDR = 32'h0001_0000,
    parameter int unsigned REC_BYTES = 32'd8,
    localparam int         REC_W     = NUM_IDX * IDX_W + 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_op,
    input  logic [NO_W-1:0]     req_no,
    input  logic [REC_W-1:0]    req_wdata,
    input  logic [NUM_IDX:0]    req_mask,
    output logic                resp_valid,
    output logic [REC_W-1:0]    resp_rdata,
    output logic                resp_err,
    output logic                ar_valid,
    input  logic                ar_ready,
    output logic [ADDR_W-1:0]   ar_addr,
    input  logic                r_valid,
    output logic                r_ready,
    input  logic [DATA_W-1:0]   r_data,
    input  logic [1:0]          r_resp,
    output logic                aw_valid,
    input  logic                aw_ready,
    output logic [ADDR_W-1:0]   aw_addr,
    output logic                w_valid,
    input  logic                w_ready,
    output logic [DATA_W-1:0]   w_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [1:0]          b_resp
);

    if (REC_W > DATA_W) begin : g_width_err
        $error("dir_dram_bridge: record width exceeds DATA_W");
    end

    if (DATA_W > REC_W) begin : g_unused_hi
        logic unused_hi_s;
        assign unused_hi_s = ^r_data[DATA_W-1:REC_W];
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_R_ADDR    = 3'd1,
        S_R_DATA    = 3'd2,
        S_W_ADDR    = 3'd3,
        S_W_DATA    = 3'd4,
        S_WAIT_RESP = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(REC_BYTES);

    // Bit-level enable built from the per-field mask: date occupies [8:0], idx[k] sits above it.
    function automatic logic [REC_W-1:0] field_mask(input logic [NUM_IDX:0] m);
        logic [REC_W-1:0] fm;
        fm      = {REC_W{1'b0}};
        fm[8:0] = {9{m[NUM_IDX]}};
        for (int k = 0; k < NUM_IDX; k++) begin
            fm[9 + k*IDX_W +: IDX_W] = {IDX_W{m[k]}};
        end
        return fm;
    endfunction

    function automatic logic [REC_W-1:0] merge_rec(input logic [REC_W-1:0] old_rec,
                                                   input logic [REC_W-1:0] new_rec,
                                                   input logic [NUM_IDX:0] m);
        logic [REC_W-1:0] fm;
        fm = field_mask(m);
        return (new_rec & fm) | (old_rec & ~fm);
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [REC_W-1:0]   wr_q, wr_d;
    logic [NUM_IDX:0]   mask_q, mask_d;
    logic [REC_W-1:0]   rd_q, rd_d;
    logic               err_q, err_d;
    logic [REC_W-1:0]   resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;

    // State and captured-transaction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 2'd0;
            addr_q       <= {ADDR_W{1'b0}};
            wr_q         <= {REC_W{1'b0}};
            mask_q       <= {(NUM_IDX+1){1'b0}};
            rd_q         <= {REC_W{1'b0}};
            err_q        <= 1'b0;
            resp_rdata_q <= {REC_W{1'b0}};
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            mask_q       <= mask_d;
            rd_q         <= rd_d;
            err_q        <= err_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next-state logic; the response registers change only on entry to DONE so they hold between pulses.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        mask_d       = mask_q;
        rd_d         = rd_q;
        err_d        = err_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    addr_d  = BASE_A + ADDR_W'(req_no) * STRIDE_A;
                    wr_d    = req_wdata;
                    mask_d  = req_mask;
                    err_d   = 1'b0;
                    state_d = (req_op == 2'd1) ? S_W_ADDR : S_R_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_R_ADDR: begin
                if (ar_ready) state_d = S_R_DATA;
                else          state_d = S_R_ADDR;
            end
            S_R_DATA: begin
                if (r_valid) begin
                    rd_d  = r_data[REC_W-1:0];
                    err_d = err_q | (r_resp != 2'b00);
                    if ((op_q == 2'd2) && (r_resp == 2'b00)) begin
                        wr_d    = merge_rec(r_data[REC_W-1:0], wr_q, mask_q);
                        state_d = S_W_ADDR;
                    end else begin
                        resp_rdata_d = r_data[REC_W-1:0];
                        resp_err_d   = err_q | (r_resp != 2'b00);
                        state_d      = S_DONE;
                    end
                end else begin
                    state_d = S_R_DATA;
                end
            end
            S_W_ADDR: begin
                if (aw_ready) state_d = S_W_DATA;
                else          state_d = S_W_ADDR;
            end
            S_W_DATA: begin
                if (w_ready) state_d = S_WAIT_RESP;
                else         state_d = S_W_DATA;
            end
            S_WAIT_RESP: begin
                if (b_valid) begin
                    err_d        = err_q | (b_resp != 2'b00);
                    resp_err_d   = err_q | (b_resp != 2'b00);
                    resp_rdata_d = (op_q == 2'd1) ? {REC_W{1'b0}} : rd_q;
                    state_d      = S_DONE;
                end else begin
                    state_d = S_WAIT_RESP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready  = (state_q == S_IDLE);
    assign ar_valid   = (state_q == S_R_ADDR);
    assign r_ready    = (state_q == S_R_DATA);
    assign aw_valid   = (state_q == S_W_ADDR);
    assign w_valid    = (state_q == S_W_DATA);
    assign b_ready    = (state_q == S_WAIT_RESP);
    assign resp_valid = (state_q == S_DONE);
    assign ar_addr    = addr_q;
    assign aw_addr    = addr_q;
    assign w_data     = DATA_W'(wr_q);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
